// File: rtl/data_memory_responder_pkg.sv
// ----------------------------------------------------------------------------
// data_memory_responder_pkg
// Shared types and constants for the Memory-stage data bus responder.
//   dmemState_e        : responder FSM states
//   DMEM_DEFAULT_DEPTH : default RAM depth in 32-bit words
//   DMEM_WORD_W        : data word width on the bus and in the RAM
//   DMEM_CNT_W         : width of the wait-state counter
// ----------------------------------------------------------------------------
package data_memory_responder_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        READ_WAIT  = 2'd1,
        WRITE_WAIT = 2'd2,
        RESPOND    = 2'd3
    } dmemState_e;

    localparam int DMEM_DEFAULT_DEPTH = 1024;
    localparam int DMEM_WORD_W        = 32;
    localparam int DMEM_CNT_W         = 16;

endpackage

// File: rtl/data_memory_responder_if.sv
// ----------------------------------------------------------------------------
// data_memory_responder_if
// Memory-stage data bus between the pipeline (master) and the responder (slave).
//   loadRequest         master->slave  level load request
//   storeValid          master->slave  level store request, held until storeComplete
//   addressRegister     master->slave  byte address
//   storeData           master->slave  lane-aligned store data
//   realStoreByteEnable master->slave  per-lane write enable
//   loadData            slave->master  aligned load word
//   loadDataValid       slave->master  one-cycle load response pulse
//   storeComplete       slave->master  one-cycle store response pulse
//   accessFault         slave->master  one-cycle fault flag with the response
// ----------------------------------------------------------------------------
interface data_memory_responder_if;
    import data_memory_responder_pkg::*;

    logic                   loadRequest;
    logic                   storeValid;
    logic [DMEM_WORD_W-1:0] addressRegister;
    logic [DMEM_WORD_W-1:0] storeData;
    logic [3:0]             realStoreByteEnable;
    logic [DMEM_WORD_W-1:0] loadData;
    logic                   loadDataValid;
    logic                   storeComplete;
    logic                   accessFault;

    modport master (
        output loadRequest, storeValid, addressRegister, storeData, realStoreByteEnable,
        input  loadData, loadDataValid, storeComplete, accessFault
    );

    modport slave (
        input  loadRequest, storeValid, addressRegister, storeData, realStoreByteEnable,
        output loadData, loadDataValid, storeComplete, accessFault
    );

endinterface

// File: rtl/data_memory_responder_ram.sv
// ----------------------------------------------------------------------------
// dmem_ram_array
// Single-port synchronous word RAM with per-byte write enables and a
// one-cycle registered read. No reset on storage or read register so it maps
// onto block RAM.
//   clk_i   : clock
//   addr_i  : word index
//   wdata_i : write data (lane aligned)
//   be_i    : per-lane write enable
//   we_i    : write strobe
//   re_i    : read strobe; rdata_o updates on the next edge and holds otherwise
//   rdata_o : read data register
// ----------------------------------------------------------------------------
module dmem_ram_array
    import data_memory_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = DMEM_DEFAULT_DEPTH,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic                   clk_i,
    input  logic [ADDR_W-1:0]      addr_i,
    input  logic [DMEM_WORD_W-1:0] wdata_i,
    input  logic [3:0]             be_i,
    input  logic                   we_i,
    input  logic                   re_i,
    output logic [DMEM_WORD_W-1:0] rdata_o
);

    logic [DMEM_WORD_W-1:0] mem_q [DEPTH_WORDS];
    logic [DMEM_WORD_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int lane = 0; lane < 4; lane++) begin
                if (be_i[lane]) begin
                    mem_q[addr_i][8*lane +: 8] <= wdata_i[8*lane +: 8];
                end
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory_responder.sv
// ----------------------------------------------------------------------------
// data_memory_responder
// Responder for the Memory-stage data bus: serves one load or byte-enabled
// store at a time against an on-chip word RAM with programmable wait states.
//   clock : single clock, posedge
//   reset : synchronous, active-high; aborts any transaction in flight
//   bus   : data_memory_responder_if.slave (requests in, pulses/data out)
// Parameters: DEPTH_WORDS (power of two), BASE_ADDRESS (4-byte aligned),
//   READ_LATENCY / WRITE_LATENCY (>=1, capture edge to response pulse).
// Optional feature macro: DMEM_BOUNDS_CHECK_EN
//   defined   : addresses below BASE_ADDRESS or past the RAM skip the RAM,
//               return 0 and raise accessFault with the normal response.
//   undefined : word index wraps modulo DEPTH_WORDS, accessFault tied 0.
// ----------------------------------------------------------------------------
module data_memory_responder
    import data_memory_responder_pkg::*;
#(
    parameter int          DEPTH_WORDS   = DMEM_DEFAULT_DEPTH,
    parameter logic [31:0] BASE_ADDRESS  = 32'h0000_0000,
    parameter int          READ_LATENCY  = 1,
    parameter int          WRITE_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    data_memory_responder_if.slave bus
);

    localparam int ADDR_W = $clog2(DEPTH_WORDS);

    dmemState_e             state_q, state_d;
    logic [DMEM_CNT_W-1:0]  count_q, count_d;
    logic                   op_read_q, op_read_d;
    logic                   fault_q, fault_d;
    logic [DMEM_WORD_W-1:0] load_data_q, load_data_d;

    // Captured request; datapath only, never reset.
    logic [ADDR_W-1:0]      idx_q, idx_d;
    logic [DMEM_WORD_W-1:0] wdata_q, wdata_d;
    logic [3:0]             be_q, be_d;

    logic [DMEM_WORD_W-1:0] offset_c;
    logic [ADDR_W-1:0]      idx_cap_c;
    logic                   fault_cap_c;
    logic                   ram_we_c, ram_re_c;
    logic [DMEM_WORD_W-1:0] ram_rdata;
    logic [DMEM_WORD_W-1:0] resp_data_c;

    // Byte offset from the window base; bits [1:0] drop out of the index.
    assign offset_c  = bus.addressRegister - BASE_ADDRESS;
    assign idx_cap_c = ADDR_W'(offset_c >> 2);

`ifdef DMEM_BOUNDS_CHECK_EN
    localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) << 2;
    assign fault_cap_c = (bus.addressRegister < BASE_ADDRESS) ||
                         ({1'b0, offset_c} >= SPAN_BYTES);
`else
    assign fault_cap_c = 1'b0;
`endif

    // Faulted loads return zero instead of whatever the RAM register holds.
    assign resp_data_c = fault_q ? '0 : ram_rdata;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        op_read_d   = op_read_q;
        fault_d     = fault_q;
        load_data_d = load_data_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        ram_we_c    = 1'b0;
        ram_re_c    = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Store has priority; a load held alongside it is taken on
                // the IDLE cycle after the store's RESPOND.
                if (bus.storeValid) begin
                    idx_d     = idx_cap_c;
                    wdata_d   = bus.storeData;
                    be_d      = bus.realStoreByteEnable;
                    fault_d   = fault_cap_c;
                    op_read_d = 1'b0;
                    count_d   = DMEM_CNT_W'(WRITE_LATENCY - 1);
                    state_d   = WRITE_WAIT;
                end else if (bus.loadRequest) begin
                    idx_d     = idx_cap_c;
                    fault_d   = fault_cap_c;
                    op_read_d = 1'b1;
                    count_d   = DMEM_CNT_W'(READ_LATENCY - 1);
                    state_d   = READ_WAIT;
                end
            end
            READ_WAIT, WRITE_WAIT: begin
                if (count_q != '0) begin
                    count_d = count_q - 1'b1;
                end else begin
                    // Last wait cycle: the RAM op lands on this edge so the
                    // read register is valid during RESPOND.
                    if (!fault_q) begin
                        ram_re_c = (state_q == READ_WAIT);
                        ram_we_c = (state_q == WRITE_WAIT);
                    end
                    state_d = RESPOND;
                end
            end
            RESPOND: begin
                if (op_read_q) begin
                    load_data_d = resp_data_c;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            op_read_q   <= 1'b0;
            fault_q     <= 1'b0;
            load_data_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            op_read_q   <= op_read_d;
            fault_q     <= fault_d;
            load_data_q <= load_data_d;
        end
    end

    always_ff @(posedge clock) begin
        idx_q   <= idx_d;
        wdata_q <= wdata_d;
        be_q    <= be_d;
    end

    // A reset landing on the commit edge must not let the store through.
    dmem_ram_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (ADDR_W)
    ) u_ram (
        .clk_i   (clock),
        .addr_i  (idx_q),
        .wdata_i (wdata_q),
        .be_i    (be_q),
        .we_i    (ram_we_c & ~reset),
        .re_i    (ram_re_c & ~reset),
        .rdata_o (ram_rdata)
    );

    // The RAM read register supplies the word during RESPOND; load_data_q
    // keeps it afterwards until the next load responds.
    assign bus.loadData      = (state_q == RESPOND && op_read_q) ? resp_data_c : load_data_q;
    assign bus.loadDataValid = (state_q == RESPOND) &&  op_read_q;
    assign bus.storeComplete = (state_q == RESPOND) && !op_read_q;
    assign bus.accessFault   = (state_q == RESPOND) &&  fault_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// ----------------------------------------------------------------------------
// tb_data_memory_responder
// Two responder instances: dut1 (1024 words, 1/1 latency) and dut2
// (256 words, read latency 4, write latency 3). Honors DMEM_BOUNDS_CHECK_EN.
// ----------------------------------------------------------------------------
module tb_data_memory_responder;

    localparam int D1 = 1024;
    localparam int D2 = 256;
    localparam int RL1 = 1, WL1 = 1, RL2 = 4, WL2 = 3;

    logic clock = 1'b0;
    logic rst1, rst2;
    always #5 clock = ~clock;

    data_memory_responder_if bus1();
    data_memory_responder_if bus2();

    data_memory_responder #(.DEPTH_WORDS(D1), .BASE_ADDRESS(32'h0),
                            .READ_LATENCY(RL1), .WRITE_LATENCY(WL1))
        dut1 (.clock(clock), .reset(rst1), .bus(bus1));

    data_memory_responder #(.DEPTH_WORDS(D2), .BASE_ADDRESS(32'h0),
                            .READ_LATENCY(RL2), .WRITE_LATENCY(WL2))
        dut2 (.clock(clock), .reset(rst2), .bus(bus2));

    int n_cmp = 0;
    int n_fail = 0;

    // Reference memory for dut2, word granular.
    logic [31:0] m2 [D2];

    typedef struct {
        bit          st;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic bit model_fault(input logic [31:0] addr, input int depth);
`ifdef DMEM_BOUNDS_CHECK_EN
        return (64'(addr) >= 64'(depth) * 4);
`else
        return (depth < 0) && (addr == 0);  // never true: no range check
`endif
    endfunction

    function automatic int model_idx(input logic [31:0] addr, input int depth);
        return int'((addr >> 2) % depth);
    endfunction

    function automatic void model_store2(input logic [31:0] addr, input logic [31:0] data,
                                         input logic [3:0] be);
        int idx;
        if (model_fault(addr, D2)) return;
        idx = model_idx(addr, D2);
        for (int l = 0; l < 4; l++)
            if (be[l]) m2[idx][8*l +: 8] = data[8*l +: 8];
    endfunction

    function automatic logic [31:0] model_load2(input logic [31:0] addr);
        if (model_fault(addr, D2)) return 32'h0;
        return m2[model_idx(addr, D2)];
    endfunction

    task automatic drive(input int sel, input bit st, input bit ld, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] be);
        if (sel == 1) begin
            bus1.storeValid = st; bus1.loadRequest = ld; bus1.addressRegister = addr;
            bus1.storeData = data; bus1.realStoreByteEnable = be;
        end else begin
            bus2.storeValid = st; bus2.loadRequest = ld; bus2.addressRegister = addr;
            bus2.storeData = data; bus2.realStoreByteEnable = be;
        end
    endtask

    function automatic logic [31:0] get_data(input int sel);
        return (sel == 1) ? bus1.loadData : bus2.loadData;
    endfunction

    // {loadDataValid, storeComplete, accessFault}
    function automatic logic [2:0] get_flags(input int sel);
        return (sel == 1) ? {bus1.loadDataValid, bus1.storeComplete, bus1.accessFault}
                          : {bus2.loadDataValid, bus2.storeComplete, bus2.accessFault};
    endfunction

    // One transaction: drive at negedge, count sampled cycles to the pulse.
    // The capture edge is sample 1, so a latency-L response shows at sample L+1.
    task automatic do_txn(input int sel, input bit st, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] be,
                          input logic [31:0] exp_data, input bit exp_fault, input string tag);
        int n, lat;
        bit got;
        logic [2:0] fl;
        logic [31:0] d;
        lat = (sel == 1) ? (st ? WL1 : RL1) : (st ? WL2 : RL2);
        n = 0; got = 0; fl = '0; d = '0;
        @(negedge clock);
        drive(sel, st, !st, addr, data, be);
        while (!got && n < 40) begin
            @(posedge clock); #1;
            n++;
            fl = get_flags(sel);
            if (st ? fl[1] : fl[2]) begin
                got = 1;
                d = get_data(sel);
            end
        end
        drive(sel, 1'b0, 1'b0, addr, data, be);
        check({tag, " latency"}, 32'(n), 32'(lat + 1));
        check({tag, " fault"}, {31'h0, fl[0]}, {31'h0, exp_fault});
        if (!st) check({tag, " data"}, d, exp_data);
        @(posedge clock); #1;
    endtask

    initial begin
        int pulses [3];
        int np, sc_n, lv_n;
        logic [31:0] last_load, v1, a, dd, lv_d;
        logic [3:0] be;
        bit st;

        rst1 = 1'b1; rst2 = 1'b1;
        drive(1, 0, 0, 32'h0, 32'h0, 4'h0);
        drive(2, 0, 0, 32'h0, 32'h0, 4'h0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        rst1 = 1'b0; rst2 = 1'b0;

        // Idle after reset: nothing pulses, loadData is zero.
        for (int c = 0; c < 10; c++) begin
            @(posedge clock); #1;
            check("idle flags dut1", {29'h0, get_flags(1)}, 32'h0);
            check("idle data dut1", get_data(1), 32'h0);
            check("idle flags dut2", {29'h0, get_flags(2)}, 32'h0);
            check("idle data dut2", get_data(2), 32'h0);
        end

        // Directed vectors on dut1.
        tbl[0]  = '{1, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0};
        tbl[1]  = '{0, 32'h10,   32'h0,        4'h0, 32'hDEADBEEF};
        tbl[2]  = '{1, 32'h20,   32'h11223344, 4'hF, 32'h0};
        tbl[3]  = '{1, 32'h20,   32'h0000AB00, 4'b0010, 32'h0};
        tbl[4]  = '{0, 32'h20,   32'h0,        4'h0, 32'h1122AB44};
        tbl[5]  = '{1, 32'h0,    32'h0BADC0DE, 4'hF, 32'h0};
        tbl[6]  = '{1, 32'h1003, 32'hCAFEF00D, 4'hF, 32'h0};
`ifdef DMEM_BOUNDS_CHECK_EN
        tbl[7]  = '{0, 32'h0,    32'h0,        4'h0, 32'h0BADC0DE};
        tbl[8]  = '{0, 32'h1002, 32'h0,        4'h0, 32'h0};
`else
        tbl[7]  = '{0, 32'h0,    32'h0,        4'h0, 32'hCAFEF00D};
        tbl[8]  = '{0, 32'h1002, 32'h0,        4'h0, 32'hCAFEF00D};
`endif
        tbl[9]  = '{1, 32'h30,   32'h55667788, 4'hF, 32'h0};
        tbl[10] = '{1, 32'h30,   32'hFFFFFFFF, 4'h0, 32'h0};
        tbl[11] = '{0, 32'h31,   32'h0,        4'h0, 32'h55667788};
        tbl[12] = '{1, 32'h40,   32'h00000000, 4'hF, 32'h0};
        tbl[13] = '{1, 32'h40,   32'hAABBCCDD, 4'b1001, 32'h0};
        tbl[14] = '{0, 32'h40,   32'h0,        4'h0, 32'hAA0000DD};

        last_load = 32'h0;
        for (int i = 0; i < 15; i++) begin
            do_txn(1, tbl[i].st, tbl[i].addr, tbl[i].data, tbl[i].be, tbl[i].exp,
                   model_fault(tbl[i].addr, D1), $sformatf("vec%0d", i));
            if (tbl[i].st) check($sformatf("vec%0d hold", i), get_data(1), last_load);
            else last_load = tbl[i].exp;
        end

        // Store and load raised together: store first, then RESPOND, IDLE and
        // READ_WAIT separate the two pulses.
        @(negedge clock);
        drive(1, 1, 1, 32'h50, 32'h77777777, 4'hF);
        sc_n = -1; lv_n = -1; lv_d = '0;
        for (int n = 1; n <= 20 && lv_n < 0; n++) begin
            @(posedge clock); #1;
            if (bus1.storeComplete && sc_n < 0) begin
                sc_n = n;
                bus1.storeValid = 1'b0;
            end
            if (bus1.loadDataValid && lv_n < 0) begin
                lv_n = n;
                lv_d = bus1.loadData;
                bus1.loadRequest = 1'b0;
            end
        end
        drive(1, 0, 0, 32'h0, 32'h0, 4'h0);
        check("both store pulse", 32'(sc_n), 32'd2);
        check("both load pulse", 32'(lv_n), 32'd5);
        check("both load data", lv_d, 32'h77777777);
        @(posedge clock); #1;

        // Fill dut2 and its model.
        for (int i = 0; i < D2; i++) begin
            dd = 32'h9E3779B9 * i + 32'h1;
            model_store2(32'(i * 4), dd, 4'hF);
            do_txn(2, 1, 32'(i * 4), dd, 4'hF, 32'h0, 1'b0, "fill");
        end

        // Held load with latency 4: pulses at samples 5 and 11, each one cycle.
        @(negedge clock);
        drive(2, 0, 1, 32'h04, 32'h0, 4'h0);
        np = 0;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clock); #1;
            if (bus2.loadDataValid) begin
                if (np < 3) pulses[np] = n;
                np++;
                check("held load data", bus2.loadData, m2[1]);
            end
        end
        drive(2, 0, 0, 32'h0, 32'h0, 4'h0);
        check("held pulse count", 32'(np), 32'd2);
        if (np >= 2) begin
            check("held first pulse", 32'(pulses[0]), 32'd5);
            check("held second pulse", 32'(pulses[1]), 32'd11);
        end
        @(posedge clock); #1;

        // Out-of-window load (256 words -> 0x400 is one past the end).
        do_txn(2, 0, 32'h400, 32'h0, 4'h0, model_load2(32'h400),
               model_fault(32'h400, D2), "edge 0x400");

        // Reset on the cycle the store would commit: no pulse, word unchanged.
        v1 = m2[2];
        @(negedge clock);
        drive(2, 1, 0, 32'h08, 32'h12345678, 4'hF);
        @(posedge clock);
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        rst2 = 1'b1;
        drive(2, 0, 0, 32'h08, 32'h0, 4'h0);
        np = 0;
        @(posedge clock); #1;
        if (bus2.storeComplete) np++;
        @(negedge clock);
        rst2 = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(posedge clock); #1;
            if (bus2.storeComplete) np++;
        end
        check("reset abort pulses", 32'(np), 32'd0);
        check("reset loadData", bus2.loadData, 32'h0);
        do_txn(2, 0, 32'h08, 32'h0, 4'h0, v1, 1'b0, "reset abort word");

        // Random traffic on dut2 against the model.
        for (int i = 0; i < 80; i++) begin
            st = $urandom_range(0, 1) == 1;
            a  = 32'($urandom_range(0, 32'h7FF));
            dd = $urandom;
            be = 4'($urandom_range(0, 15));
            if (st) begin
                do_txn(2, 1, a, dd, be, 32'h0, model_fault(a, D2), "rand store");
                model_store2(a, dd, be);
            end else begin
                do_txn(2, 0, a, 32'h0, 4'h0, model_load2(a), model_fault(a, D2), "rand load");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
